// File: rtl/gated_capture_reg_pkg.sv
// Shared CPU control-path package: program counter and ALU flag types,
// plus the capture-condition helper used by the gated capture register.
package cpu_ctrl_pkg;

    localparam int unsigned PC_WIDTH   = 32;
    localparam int unsigned FLAG_WIDTH = 2;

    localparam logic [PC_WIDTH-1:0] PC_RESET = 32'h0;

    typedef logic [PC_WIDTH-1:0]   pc_t;
    typedef logic [FLAG_WIDTH-1:0] alu_flags_t;

    // A register only captures when the global run gate and its local enable agree.
    function automatic logic cap_of(input logic start, input logic en);
        return start & en;
    endfunction

endpackage

// File: rtl/gated_capture_reg_if.sv
// Bus bundle for gated_capture_reg: gate/enable/data towards the register,
// state and sticky status back. The clr member exists only when REG_CLR_EN is defined.
interface gated_capture_reg_if #(
    parameter int unsigned WIDTH = cpu_ctrl_pkg::PC_WIDTH
);

    logic             start;
    logic             en;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             loaded;
`ifdef REG_CLR_EN
    logic             clr;

    modport master (
        output start,
        output en,
        output d,
        output clr,
        input  q,
        input  loaded
    );

    modport slave (
        input  start,
        input  en,
        input  d,
        input  clr,
        output q,
        output loaded
    );
`else
    modport master (
        output start,
        output en,
        output d,
        input  q,
        input  loaded
    );

    modport slave (
        input  start,
        input  en,
        input  d,
        output q,
        output loaded
    );
`endif

endinterface

// File: rtl/gated_capture_reg_cell.sv
// One bit of gated state: reset beats clear, clear beats capture, otherwise hold.
module gated_capture_cell #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic cap_i,
    input  logic d_i,
    output logic q_o
);

    logic q_q;

    // Single state bit with reset > clr > capture > hold priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= RESET_VAL;
        end else if (clr_i) begin
            q_q <= RESET_VAL;
        end else if (cap_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/gated_capture_reg.sv
// Generic gated capture register for the CPU control path (PC, ALU flag
// latch, COM sticky flag). Captures d into q when start & en; holds otherwise.
// 'loaded' goes high on the first capture and stays high until reset/clear.
// Optional synchronous clear is compiled in with the REG_CLR_EN macro.
module gated_capture_reg
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned      WIDTH     = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                clk,
    input logic                reset,
    gated_capture_reg_if.slave bus
);

    logic             cap;
    logic             clr;
    logic [WIDTH-1:0] q_vec;
    logic             loaded;

    assign cap = cap_of(bus.start, bus.en);

`ifdef REG_CLR_EN
    assign clr = bus.clr;
`else
    assign clr = 1'b0;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gated_capture_cell #(
            .RESET_VAL (RESET_VAL[i])
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .clr_i (clr),
            .cap_i (cap),
            .d_i   (bus.d[i]),
            .q_o   (q_vec[i])
        );
    end

    // The sticky flag is just another cell that always captures a one.
    gated_capture_cell #(
        .RESET_VAL (1'b0)
    ) u_loaded (
        .clk   (clk),
        .reset (reset),
        .clr_i (clr),
        .cap_i (cap),
        .d_i   (1'b1),
        .q_o   (loaded)
    );

    assign bus.q      = q_vec;
    assign bus.loaded = loaded;

endmodule

// File: tb/tb_gated_capture_reg.sv
// Self-checking bench for gated_capture_reg: three instances (32-bit/reset 0,
// 2-bit/reset 01, 1-bit sticky) driven by directed steps then random traffic,
// compared against a rule-level model. Honours REG_CLR_EN when defined.
module tb_gated_capture_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst32, rst2, rst1;
    logic clr32 = 1'b0;
    logic clr2  = 1'b0;
    logic clr1  = 1'b0;

    gated_capture_reg_if #(.WIDTH(32)) b32();
    gated_capture_reg_if #(.WIDTH(2))  b2();
    gated_capture_reg_if #(.WIDTH(1))  b1();

`ifdef REG_CLR_EN
    assign b32.clr = clr32;
    assign b2.clr  = clr2;
    assign b1.clr  = clr1;
`endif

    gated_capture_reg #(.WIDTH(32), .RESET_VAL(32'h0)) u_dut32 (
        .clk   (clk),
        .reset (rst32),
        .bus   (b32)
    );

    gated_capture_reg #(.WIDTH(2), .RESET_VAL(2'b01)) u_dut2 (
        .clk   (clk),
        .reset (rst2),
        .bus   (b2)
    );

    gated_capture_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (b1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state, advanced from the priority rules once per edge.
    logic [31:0] m32_q;
    logic        m32_l;
    logic [1:0]  m2_q;
    logic        m2_l;
    logic        m1_q;
    logic        m1_l;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Advance the model with the inputs present before the edge, then compare after it.
    task automatic tick();
        if (rst32 || clr32) begin
            m32_q = 32'h0;
            m32_l = 1'b0;
        end else if (b32.start && b32.en) begin
            m32_q = b32.d;
            m32_l = 1'b1;
        end
        if (rst2 || clr2) begin
            m2_q = 2'b01;
            m2_l = 1'b0;
        end else if (b2.start && b2.en) begin
            m2_q = b2.d;
            m2_l = 1'b1;
        end
        if (rst1 || clr1) begin
            m1_q = 1'b0;
            m1_l = 1'b0;
        end else if (b1.start && b1.en) begin
            m1_q = b1.d;
            m1_l = 1'b1;
        end
        @(posedge clk);
        #1;
        check("q32", 64'(b32.q), 64'(m32_q));
        check("loaded32", 64'(b32.loaded), 64'(m32_l));
        check("q2", 64'(b2.q), 64'(m2_q));
        check("loaded2", 64'(b2.loaded), 64'(m2_l));
        check("q1", 64'(b1.q), 64'(m1_q));
        check("loaded1", 64'(b1.loaded), 64'(m1_l));
    endtask

    initial begin
        // Reset with a capture pending on every instance.
        rst32 = 1'b1; rst2 = 1'b1; rst1 = 1'b1;
        b32.start = 1'b1; b32.en = 1'b1; b32.d = 32'hDEADBEEF;
        b2.start  = 1'b1; b2.en  = 1'b1; b2.d  = 2'b10;
        b1.start  = 1'b1; b1.en  = 1'b1; b1.d  = 1'b1;
        tick();
        check("rst_q32_e1", 64'(b32.q), 64'h0);
        tick();
        check("rst_q32_e2", 64'(b32.q), 64'h0);
        check("rst_loaded32", 64'(b32.loaded), 64'h0);
        check("rst_q2", 64'(b2.q), 64'h1);

        // Capture then hold with en low.
        rst32 = 1'b0; rst2 = 1'b0; rst1 = 1'b0;
        b2.en = 1'b0; b1.en = 1'b0;
        b32.d = 32'h4;
        tick();
        check("cap_q32", 64'(b32.q), 64'h4);
        check("cap_loaded32", 64'(b32.loaded), 64'h1);
        b32.en = 1'b0; b32.d = 32'h8;
        tick();
        tick();
        check("hold_q32", 64'(b32.q), 64'h4);

        // start low freezes regardless of en.
        b32.start = 1'b0; b32.en = 1'b1; b32.d = 32'hC;
        repeat (3) tick();
        check("gate_q32", 64'(b32.q), 64'h4);
        check("gate_loaded32", 64'(b32.loaded), 64'h1);
        b32.start = 1'b1;
        tick();
        check("ungate_q32", 64'(b32.q), 64'hC);
        b32.en = 1'b0;

        // Reset collides with a capture on the 2-bit instance.
        b2.en = 1'b1; b2.d = 2'b10;
        tick();
        check("cap_q2", 64'(b2.q), 64'h2);
        rst2 = 1'b1; b2.d = 2'b11;
        tick();
        check("collide_q2", 64'(b2.q), 64'h1);
        check("collide_loaded2", 64'(b2.loaded), 64'h0);
        rst2 = 1'b0; b2.en = 1'b0;

        // Sticky 1-bit usage: one pulse, then hold until reset.
        b1.en = 1'b1; b1.d = 1'b1;
        tick();
        b1.en = 1'b0; b1.d = 1'b0;
        repeat (10) begin
            tick();
            check("sticky_q1", 64'(b1.q), 64'h1);
        end
        rst1 = 1'b1;
        tick();
        check("sticky_rst_q1", 64'(b1.q), 64'h0);
        rst1 = 1'b0;

`ifdef REG_CLR_EN
        // Clear beats a simultaneous capture; the next capture goes through.
        b32.en = 1'b1; b32.d = 32'h10;
        tick();
        check("pre_clr_q32", 64'(b32.q), 64'h10);
        clr32 = 1'b1; b32.d = 32'h20;
        tick();
        check("clr_q32", 64'(b32.q), 64'h0);
        check("clr_loaded32", 64'(b32.loaded), 64'h0);
        clr32 = 1'b0;
        tick();
        check("post_clr_q32", 64'(b32.q), 64'h20);
        check("post_clr_loaded32", 64'(b32.loaded), 64'h1);
        b32.en = 1'b0;
`endif

        // Random traffic on all three instances.
        repeat (400) begin
            rst32 = ($urandom_range(0, 15) == 0);
            rst2  = ($urandom_range(0, 15) == 0);
            rst1  = ($urandom_range(0, 15) == 0);
`ifdef REG_CLR_EN
            clr32 = ($urandom_range(0, 7) == 0);
            clr2  = ($urandom_range(0, 7) == 0);
            clr1  = ($urandom_range(0, 7) == 0);
`endif
            b32.start = ($urandom_range(0, 3) != 0);
            b32.en    = 1'($urandom);
            b32.d     = $urandom;
            b2.start  = ($urandom_range(0, 3) != 0);
            b2.en     = 1'($urandom);
            b2.d      = 2'($urandom);
            b1.start  = ($urandom_range(0, 3) != 0);
            b1.en     = 1'($urandom);
            b1.d      = 1'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
